// File: rtl/matrix_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mem_responder
// Purpose  : Memory-side responder for the matrix processor. Serves single-
//            word loads of matrix elements (16 words from mat_base) and vector
//            elements (4 words from vec_base) over the shared memory bus, and
//            drains buffered result writes to consecutive addresses starting
//            at out_base.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            wi_init_i, *_base_i - base latch / write-counter + overflow clear
//            ld_*              - processor load request / response
//            wr_*              - processor result-write FIFO push / status
//            busy_o            - FSM not idle or write FIFO not empty
//            bus_*             - shared memory bus master side
// Options  : `define MATRIX_RESP_TIMEOUT_EN adds a read watchdog that answers
//            a stalled load after TIMEOUT cycles with ld_err_o=1, data 0.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WFIFO_DEPTH = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wi_init_i,
  input  logic [ADDR_W-1:0] mat_base_i,
  input  logic [ADDR_W-1:0] vec_base_i,
  input  logic [ADDR_W-1:0] out_base_i,
  input  logic              ld_req_i,
  input  logic              ld_vec_i,
  input  logic [3:0]        ld_idx_i,
  output logic              ld_valid_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              ld_err_o,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_full_o,
  output logic              wr_ovf_o,
  output logic              busy_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(WFIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RESP    = 3'd3,
    WR_REQ  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mat_base_q, mat_base_d;
  logic [ADDR_W-1:0] vec_base_q, vec_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] fifo_q [WFIFO_DEPTH];

  logic              busy;
  logic              fifo_full;
  logic              pop;
  logic              push_acc;

`ifdef MATRIX_RESP_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  assign fifo_full = (cnt_q == C_DEPTH);
  assign busy      = (state_q != IDLE) || (cnt_q != '0);

  always_comb begin
    state_d     = state_q;
    mat_base_d  = mat_base_q;
    vec_base_d  = vec_base_q;
    out_base_d  = out_base_q;
    wr_cnt_d    = wr_cnt_q;
    ovf_d       = ovf_q;
    ld_data_d   = ld_data_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    push_acc    = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = fifo_q[rptr_q];
`ifdef MATRIX_RESP_TIMEOUT_EN
    to_cnt_d    = '0;
    err_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Loads win unless the FIFO is full; then a write must go first.
        if (fifo_full)            state_d = WR_REQ;
        else if (ld_req_i)        state_d = RD_REQ;
        else if (cnt_q != '0)     state_d = WR_REQ;
      end
      RD_REQ: begin
        bus_req_o = 1'b1;
        if (ld_vec_i) bus_addr_o = vec_base_q + ADDR_W'(ld_idx_i[1:0]);
        else          bus_addr_o = mat_base_q + ADDR_W'(ld_idx_i);
        if (bus_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
`ifdef MATRIX_RESP_TIMEOUT_EN
        // Data arriving in the expiry cycle takes precedence over the timeout.
        if (bus_rvalid_i) begin
          ld_data_d = bus_rdata_i;
          state_d   = RESP;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          ld_data_d = '0;
          err_d     = 1'b1;
          state_d   = RESP;
        end else begin
          to_cnt_d  = to_cnt_q + TO_W'(1);
        end
`else
        if (bus_rvalid_i) begin
          ld_data_d = bus_rdata_i;
          state_d   = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      WR_REQ: begin
        bus_req_o  = 1'b1;
        bus_we_o   = 1'b1;
        bus_addr_o = out_base_q + wr_cnt_q;
        if (bus_gnt_i) begin
          pop      = 1'b1;
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Init only lands while idle with an empty FIFO, so it never collides
    // with a write-counter increment or an overflow event.
    if (wi_init_i && !busy) begin
      mat_base_d = mat_base_i;
      vec_base_d = vec_base_i;
      out_base_d = out_base_i;
      wr_cnt_d   = '0;
      ovf_d      = 1'b0;
    end

    // A simultaneous pop frees a slot, so a full FIFO still takes the push.
    push_acc = wr_en_i && (!fifo_full || pop);
    if (wr_en_i && !push_acc) ovf_d = 1'b1;
    if (push_acc) wptr_d = wptr_q + PTR_W'(1);
    if (pop)      rptr_d = rptr_q + PTR_W'(1);
    case ({push_acc, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mat_base_q <= '0;
      vec_base_q <= '0;
      out_base_q <= '0;
      wr_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      ld_data_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mat_base_q <= mat_base_d;
      vec_base_q <= vec_base_d;
      out_base_q <= out_base_d;
      wr_cnt_q   <= wr_cnt_d;
      ovf_q      <= ovf_d;
      ld_data_q  <= ld_data_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_acc) fifo_q[wptr_q] <= wr_data_i;
  end

`ifdef MATRIX_RESP_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  // err_q is only ever set on the transition into RESP, so it lasts one cycle.
  assign ld_err_o = err_q;
`else
  assign ld_err_o = 1'b0;
`endif

  assign ld_valid_o = (state_q == RESP);
  assign ld_data_o  = ld_data_q;
  assign wr_full_o  = fifo_full;
  assign wr_ovf_o   = ovf_q;
  assign busy_o     = busy;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_mem_responder
// Purpose  : Self-checking bench for matrix_mem_responder. Directed load,
//            write-drain, overflow/priority, init-while-busy and reset-mid-
//            read scenarios, then a randomized mixed phase checked against a
//            transaction-level model (expected addresses, FIFO queue, sticky
//            overflow). Watchdog scenarios run when MATRIX_RESP_TIMEOUT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_mem_responder;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              wi_init_i;
  logic [ADDR_W-1:0] mat_base_i, vec_base_i, out_base_i;
  logic              ld_req_i, ld_vec_i;
  logic [3:0]        ld_idx_i;
  logic              ld_valid_o, ld_err_o;
  logic [DATA_W-1:0] ld_data_o;
  logic              wr_en_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_full_o, wr_ovf_o, busy_o;
  logic              bus_req_o, bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_gnt_i, bus_rvalid_i;
  logic [DATA_W-1:0] bus_rdata_i;

  matrix_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WFIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wi_init_i(wi_init_i),
    .mat_base_i(mat_base_i), .vec_base_i(vec_base_i), .out_base_i(out_base_i),
    .ld_req_i(ld_req_i), .ld_vec_i(ld_vec_i), .ld_idx_i(ld_idx_i),
    .ld_valid_o(ld_valid_o), .ld_data_o(ld_data_o), .ld_err_o(ld_err_o),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .wr_full_o(wr_full_o),
    .wr_ovf_o(wr_ovf_o), .busy_o(busy_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_mat, m_vec, m_out, m_wcnt;
  bit          m_ovf;
  logic [31:0] m_q[$];
  logic [31:0] push_q[$];
  bit          hs_log[$];
  int          writes_seen;
  bit          ld_active;
  logic [15:0] ld_exp_addr;
  logic [31:0] ld_exp_data;
  bit          rv_armed;
  int          rv_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] load_addr(input bit vec, input logic [3:0] idx);
    logic [15:0] a;
    if (vec) a = m_vec + {14'd0, idx[1:0]};
    else     a = m_mat + {12'd0, idx};
    return a;
  endfunction

  task automatic do_init(input logic [15:0] mb, input logic [15:0] vb, input logic [15:0] ob);
    wi_init_i = 1'b1; mat_base_i = mb; vec_base_i = vb; out_base_i = ob;
    tick();
    wi_init_i = 1'b0;
    m_mat = mb; m_vec = vb; m_out = ob; m_wcnt = '0; m_ovf = 1'b0;
  endtask

  // Immediate grant, rvalid one cycle after the grant: checks exact latency.
  task automatic load_directed(input bit vec, input logic [3:0] idx,
                               input logic [31:0] data, input logic [15:0] exp_addr);
    ld_req_i = 1'b1; ld_vec_i = vec; ld_idx_i = idx;
    tick();
    chk("rd_req", bus_req_o, 1'b1);
    chk("rd_we", bus_we_o, 1'b0);
    chk("rd_addr_lit", bus_addr_o, exp_addr);
    chk("rd_addr_model", bus_addr_o, load_addr(vec, idx));
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    chk("rd_wait_req_low", bus_req_o, 1'b0);
    chk("no_early_valid", ld_valid_o, 1'b0);
    bus_rvalid_i = 1'b1; bus_rdata_i = data;
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
    chk("ld_valid", ld_valid_o, 1'b1);
    chk("ld_data", ld_data_o, data);
    chk("ld_err", ld_err_o, 1'b0);
    ld_req_i = 1'b0;
    tick();
    chk("ld_valid_one_cycle", ld_valid_o, 1'b0);
    chk("ld_data_hold", ld_data_o, data);
  endtask

  task automatic start_load(input bit vec, input logic [3:0] idx);
    ld_req_i = 1'b1; ld_vec_i = vec; ld_idx_i = idx;
    ld_exp_addr = load_addr(vec, idx);
    ld_exp_data = $urandom;
    ld_active = 1'b1;
  endtask

  // Cycle-by-cycle bus/processor model. With drain set, stimulus stops after
  // ncyc cycles and the bus grants freely until all traffic has completed.
  task automatic run(input int ncyc, input int load_pct, input int push_pct,
                     input int gnt_pct, input int max_loads, input bit drain);
    int started = 0;
    int budget;
    budget = drain ? ncyc + 300 : ncyc;
    for (int c = 0; c < budget; c++) begin
      bit          stim, gnt, do_push;
      logic [31:0] pd;
      logic [15:0] wa;
      stim = (c < ncyc);
      if (!stim && !ld_active && m_q.size() == 0 && push_q.size() == 0) break;

      bus_rvalid_i = 1'b0;
      bus_rdata_i  = $urandom;
      if (rv_armed) begin
        if (rv_cnt == 0) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = ld_exp_data; rv_armed = 1'b0;
        end else begin
          rv_cnt--;
        end
      end

      if (ld_valid_o) begin
        chk("valid_only_when_loading", ld_active, 1'b1);
        chk("rnd_ld_data", ld_data_o, ld_exp_data);
        chk("rnd_ld_err", ld_err_o, 1'b0);
        ld_active = 1'b0; ld_req_i = 1'b0;
      end

      gnt = stim ? ($urandom_range(99) < gnt_pct) : 1'b1;
      if (bus_req_o && gnt) begin
        hs_log.push_back(bus_we_o);
        if (bus_we_o) begin
          wa = m_out + m_wcnt;
          chk("wr_addr", bus_addr_o, wa);
          chk("wr_model_nonempty", m_q.size() != 0, 1'b1);
          if (m_q.size() != 0) chk("wr_data", bus_wdata_o, m_q.pop_front());
          m_wcnt++;
          writes_seen++;
        end else begin
          chk("rd_only_when_loading", ld_active, 1'b1);
          chk("rnd_rd_addr", bus_addr_o, ld_exp_addr);
          rv_armed = 1'b1;
          rv_cnt = $urandom_range(3);
        end
      end

      do_push = 1'b0;
      pd = $urandom;
      if (push_q.size() != 0) begin
        do_push = 1'b1; pd = push_q.pop_front();
      end else if (stim && $urandom_range(99) < push_pct) begin
        do_push = 1'b1;
      end
      // Any same-cycle pop is already applied to the model queue here.
      if (do_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(pd);
        else                    m_ovf = 1'b1;
      end

      if (stim && !ld_active && started < max_loads && $urandom_range(99) < load_pct) begin
        start_load(1'($urandom_range(1)), 4'($urandom_range(15)));
        started++;
      end

      wr_en_i = do_push; wr_data_i = pd; bus_gnt_i = gnt;
      tick();
      chk("wr_full", wr_full_o, m_q.size() == DEPTH);
      chk("wr_ovf", wr_ovf_o, m_ovf);
    end
    wr_en_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    if (drain) begin
      chk("drain_completed", ld_active || m_q.size() != 0, 1'b0);
      chk("busy_after_drain", busy_o, 1'b0);
    end
  endtask

  initial begin
    int w0, n, seen;
    rst = 1'b1; wi_init_i = 1'b0; mat_base_i = '0; vec_base_i = '0; out_base_i = '0;
    ld_req_i = 1'b0; ld_vec_i = 1'b0; ld_idx_i = '0; wr_en_i = 1'b0; wr_data_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    m_mat = '0; m_vec = '0; m_out = '0; m_wcnt = '0; m_ovf = 1'b0;
    writes_seen = 0; ld_active = 1'b0; rv_armed = 1'b0; rv_cnt = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_bus_req", bus_req_o, 1'b0);
    chk("rst_ld_valid", ld_valid_o, 1'b0);
    chk("rst_ld_err", ld_err_o, 1'b0);
    chk("rst_ld_data", ld_data_o, 32'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_full", wr_full_o, 1'b0);
    chk("rst_ovf", wr_ovf_o, 1'b0);

    // Directed loads, including address wrap
    do_init(16'h0100, 16'h0300, 16'h0200);
    load_directed(1'b0, 4'd5, 32'hDEADBEEF, 16'h0105);
    load_directed(1'b1, 4'd6, 32'hCAFEF00D, 16'h0302);
    do_init(16'hFFFE, 16'h0300, 16'h0200);
    load_directed(1'b0, 4'd3, 32'h12345678, 16'h0001);

    // Write drain with constant grant
    w0 = writes_seen;
    push_q.push_back(32'h11); push_q.push_back(32'h22); push_q.push_back(32'h33);
    run(3, 0, 0, 100, 0, 1'b1);
    chk("drain_write_count", writes_seen - w0, 3);

    // Overflow with grant held low, then an ignored init, then priority
    do_init(16'h0100, 16'h0300, 16'h0400);
    for (int i = 0; i < 5; i++) push_q.push_back(32'hA0 + i);
    run(5, 0, 0, 0, 0, 1'b0);
    chk("ovf_full", wr_full_o, 1'b1);
    chk("ovf_sticky", wr_ovf_o, 1'b1);
    wi_init_i = 1'b1; mat_base_i = 16'h7000; vec_base_i = 16'h7100; out_base_i = 16'h7777;
    tick();
    wi_init_i = 1'b0;
    chk("init_ignored_ovf", wr_ovf_o, 1'b1);
    chk("init_ignored_busy", busy_o, 1'b1);
    hs_log.delete();
    w0 = writes_seen;
    run(1, 100, 0, 100, 1, 1'b1);
    chk("prio_hs_count", hs_log.size(), 5);
    if (hs_log.size() >= 2) begin
      chk("prio_first_is_write", hs_log[0], 1'b1);
      chk("prio_then_read", hs_log[1], 1'b0);
    end
    chk("ovf_write_count", writes_seen - w0, 4);

    // Randomized mixed traffic
    do_init(16'($urandom), 16'($urandom), 16'($urandom));
    run(600, 25, 35, 60, 10000, 1'b1);

`ifdef MATRIX_RESP_TIMEOUT_EN
    // Watchdog: no rvalid at all
    ld_req_i = 1'b1; ld_vec_i = 1'b0; ld_idx_i = 4'd1;
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    n = 0;
    while (!ld_valid_o && n < 200) begin tick(); n++; end
    chk("to_latency", n, TIMEOUT);
    chk("to_valid", ld_valid_o, 1'b1);
    chk("to_err", ld_err_o, 1'b1);
    chk("to_data", ld_data_o, 32'h0);
    ld_req_i = 1'b0;
    tick();
    chk("to_err_one_cycle", ld_err_o, 1'b0);
    chk("to_valid_one_cycle", ld_valid_o, 1'b0);

    // rvalid in the expiry cycle wins
    ld_req_i = 1'b1;
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    seen = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      if (ld_valid_o) seen++;
      tick();
    end
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h600DDA7A;
    tick();
    bus_rvalid_i = 1'b0;
    chk("edge_no_early_resp", seen, 0);
    chk("edge_valid", ld_valid_o, 1'b1);
    chk("edge_err", ld_err_o, 1'b0);
    chk("edge_data", ld_data_o, 32'h600DDA7A);
    ld_req_i = 1'b0;
    tick();
`endif

    // Reset during RD_WAIT with a pending write, then a late rvalid
    do_init(16'h0100, 16'h0300, 16'h0200);
    ld_req_i = 1'b1; ld_vec_i = 1'b0; ld_idx_i = 4'd2;
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0; wr_en_i = 1'b1; wr_data_i = 32'h55;
    tick();
    wr_en_i = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; ld_req_i = 1'b0;
    m_q.delete(); m_ovf = 1'b0; ld_active = 1'b0; rv_armed = 1'b0;
    chk("mid_rst_bus_req", bus_req_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_ld_data", ld_data_o, 32'h0);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBADBAD00;
    tick();
    bus_rvalid_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (ld_valid_o || bus_req_o) seen++;
      tick();
    end
    chk("late_rvalid_ignored", seen, 0);
    chk("late_rvalid_data", ld_data_o, 32'h0);
    chk("mid_rst_fifo_empty", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
